// File: rtl/writeback_stage.sv
// MEM/WB pipeline stage: registers the MEM-stage bundle, extracts load data,
// selects register-file write data, drives the fetch redirect and counts retirements.
module writeback_stage #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] memory_data_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        wbsel_i,
  input  logic              brtaken_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  output logic              valid_o,
  output logic              rf_wren_o,
  output logic [4:0]        rf_rd_o,
  output logic [DWIDTH-1:0] writeback_data_o,
  output logic              redirect_o,
  output logic [AWIDTH-1:0] next_pc_o,
  output logic [CWIDTH-1:0] instret_o
);

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_JAL = 2'd3;

  logic              valid_q, valid_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] alu_res_q, alu_res_d;
  logic [DWIDTH-1:0] mem_q, mem_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        wbsel_q, wbsel_d;
  logic              brtaken_q, brtaken_d;
  logic [4:0]        rd_q, rd_d;
  logic              regwren_q, regwren_d;
  logic [CWIDTH-1:0] instret_q, instret_d;

  logic [AWIDTH-1:0] pc_plus4_s;
  logic              taken_s;
  logic [DWIDTH-1:0] load_data_s;

  // Lanes come from the low 32 bits; extension is built at 64 bits then trimmed.
  function automatic logic [DWIDTH-1:0] load_extract(
    input logic [DWIDTH-1:0] word,
    input logic [1:0]        off,
    input logic [2:0]        f3
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [63:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    w = word[31:0];
    case (f3)
      3'b000:  r = {{56{b[7]}}, b};
      3'b100:  r = {56'd0, b};
      3'b001:  r = {{48{h[15]}}, h};
      3'b101:  r = {48'd0, h};
      3'b010:  r = {{32{w[31]}}, w};
      3'b110:  r = {32'd0, w};
      default: r = 64'(word);
    endcase
    return r[DWIDTH-1:0];
  endfunction

  // Next-state for the stage register and retire counter.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    alu_res_d = alu_res_q;
    mem_d     = mem_q;
    funct3_d  = funct3_q;
    wbsel_d   = wbsel_q;
    brtaken_d = brtaken_q;
    rd_d      = rd_q;
    regwren_d = regwren_q;
    instret_d = instret_q;
    if (stall_i) begin
      instret_d = instret_q;
    end else begin
      // A flush still loads the fields; only valid is forced low.
      valid_d   = valid_i & ~flush_i;
      pc_d      = pc_i;
      alu_res_d = alu_res_i;
      mem_d     = memory_data_i;
      funct3_d  = funct3_i;
      wbsel_d   = wbsel_i;
      brtaken_d = brtaken_i;
      rd_d      = rd_i;
      regwren_d = regwren_i;
      if (valid_q) begin
        instret_d = instret_q + {{(CWIDTH-1){1'b0}}, 1'b1};
      end else begin
        instret_d = instret_q;
      end
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      alu_res_q <= '0;
      mem_q     <= '0;
      funct3_q  <= 3'd0;
      wbsel_q   <= 2'd0;
      brtaken_q <= 1'b0;
      rd_q      <= 5'd0;
      regwren_q <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      alu_res_q <= alu_res_d;
      mem_q     <= mem_d;
      funct3_q  <= funct3_d;
      wbsel_q   <= wbsel_d;
      brtaken_q <= brtaken_d;
      rd_q      <= rd_d;
      regwren_q <= regwren_d;
      instret_q <= instret_d;
    end
  end

  assign pc_plus4_s  = pc_q + AWIDTH'(32'd4);
  assign taken_s     = brtaken_q | (wbsel_q == WB_JAL);
  assign load_data_s = load_extract(mem_q, alu_res_q[1:0], funct3_q);

  // Write-data select from the registered bundle.
  always_comb begin
    writeback_data_o = alu_res_q;
    case (wbsel_q)
      WB_ALU:  writeback_data_o = alu_res_q;
      WB_MEM:  writeback_data_o = load_data_s;
      WB_PC:   writeback_data_o = DWIDTH'(pc_q);
      WB_JAL:  writeback_data_o = DWIDTH'(pc_plus4_s);
      default: writeback_data_o = alu_res_q;
    endcase
  end

  assign valid_o    = valid_q;
  assign rf_wren_o  = valid_q & regwren_q & (rd_q != 5'd0);
  assign rf_rd_o    = rd_q;
  // Redirect fires only in the cycle the instruction actually leaves the stage.
  assign redirect_o = valid_q & taken_s & ~stall_i;
  assign next_pc_o  = taken_s ? alu_res_q[AWIDTH-1:0] : pc_plus4_s;
  assign instret_o  = instret_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered MEM/WB pipeline stage for the pipelined core (pd5 onward); successor to the combinational writeback mux.
- Captures the MEM-stage result bundle each cycle and extracts and extends load data by size and sign.
- Selects register-file write data, generates the PC redirect for taken branches and jumps, and counts retired instructions.
- Supports stall, flush and parametrised data, address and counter widths.

Parameters:
- AWIDTH, 32, address/PC width.
- DWIDTH, 32, datapath width; legal values are 32 or 64.
- CWIDTH, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- valid_i  in  1  MEM stage presents an instruction
- stall_i  in  1  hold stage register contents
- flush_i  in  1  squash the incoming instruction
- pc_i  in  AWIDTH  instruction PC
- alu_res_i  in  DWIDTH  ALU result / effective address / branch-jump target
- memory_data_i  in  DWIDTH  raw aligned memory word
- funct3_i  in  3  load size/sign encoding
- wbsel_i  in  2  wbALU/wbMEM/wbPC/wbJAL (constants.svh)
- brtaken_i  in  1  branch resolved taken
- rd_i  in  5  destination register
- regwren_i  in  1  instruction writes rd
- valid_o  out  1  registered instruction valid
- rf_wren_o  out  1  register-file write enable
- rf_rd_o  out  5  register-file write address
- writeback_data_o  out  DWIDTH  register-file write data
- redirect_o  out  1  fetch must load next_pc_o
- next_pc_o  out  AWIDTH  next sequential PC or redirect target
- instret_o  out  CWIDTH  retired-instruction count

Behaviour:
- Reset (synchronous): all stage register fields cleared, instret cleared. Resulting outputs: valid_o=0, rf_wren_o=0, rf_rd_o=0, writeback_data_o=0, redirect_o=0, next_pc_o=4, instret_o=0. Reset overrides stall and flush; an instruction in flight is discarded.
- Edge update priority: reset > stall_i (hold every field) > flush_i (valid_q<=0, other fields don't-care) > capture (valid_q<=valid_i, all fields <= inputs).
- Latency: all outputs are combinational from the stage register; inputs appear one cycle after capture.
- Load extraction (wbMEM only):
  - Byte offset is alu_res_q[1:0]; halfword offset is alu_res_q[1].
  - funct3 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half. 101 LHU: zero-extend half.
  - 010 LW: sign-extend low 32 bits to DWIDTH.
  - 110 LWU: zero-extend low 32 bits.
  - 011 LD: full word, DWIDTH=64 only.
  - Any other code: full raw word.
  - Misaligned offsets are not checked; the extracted lane uses the offset bits as given.
- writeback_data_o by wbsel:
  - wbALU: alu_res_q.
  - wbMEM: extracted load data.
  - wbPC: pc_q, zero-extended to DWIDTH.
  - wbJAL: pc_q+4, modulo 2^AWIDTH.
- rf_wren_o = valid_q & regwren_q & (rd_q!=0). rf_rd_o = rd_q. Both remain asserted while stalled; the repeated write is idempotent.
- Taken condition: taken = brtaken_q | (wbsel_q==wbJAL).
- next_pc_o = taken ? alu_res_q[AWIDTH-1:0] : pc_q+4. The +4 wraps at 2^AWIDTH.
- redirect_o = valid_q & taken & ~stall_i. It pulses exactly once per redirecting instruction, in the cycle the instruction leaves the stage.
- Retire counter: instret increments by 1 on each edge where valid_q & ~stall_i & ~reset. It wraps modulo 2^CWIDTH with no saturation.
- flush_i with valid_i=0 is a no-op beyond clearing valid. Simultaneous stall_i and flush_i: stall wins and the held instruction keeps its valid.

Test Plan:
- Reset, then valid_i=1, pc_i=0x01000000, alu_res_i=0xDEADBEEF, wbsel=wbALU, regwren=1, rd=5 -> next cycle: valid_o=1, rf_wren_o=1, rf_rd_o=5, writeback_data_o=0xDEADBEEF, next_pc_o=0x01000004, redirect_o=0; one cycle later instret_o=1.
- wbMEM with memory_data_i=0xCAFEBABE, alu_res_i[1:0]=3, LB -> writeback_data_o=0xFFFFFFCA. Same inputs with LBU -> 0x000000CA. LH with offset 2 -> 0xFFFFCAFE.
- wbJAL, pc_i=0x01000000, alu_res_i=0x01000100, rd=1 -> writeback_data_o=0x01000004, next_pc_o=0x01000100, redirect_o=1 for exactly one cycle. Repeat with rd=0 -> rf_wren_o=0, redirect_o=1.
- Branch: wbALU, brtaken_i=1, alu_res_i=0x00000040 -> redirect_o=1, next_pc_o=0x40. Hold stall_i=1 for 3 cycles -> redirect_o=0 and instret_o frozen; release -> one redirect pulse and instret+1.
- flush_i=1 with valid_i=1 -> valid_o=0, rf_wren_o=0, no instret increment. flush_i=1 with stall_i=1 -> held instruction unchanged.
- instret preloaded near 2^CWIDTH-1 (CWIDTH=4 build): two retirements -> wraps to 1. Assert reset mid-stall -> all outputs at reset values next cycle.
